// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, MDU stall,
// data-memory freeze with sticky timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MDU_LAT     = 4,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_mdu_start,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        pc_write_en,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_hold,
    output logic        idex_bubble,
    output logic        exmem_hold,
    output logic        exmem_bubble,
    output logic        memwb_bubble,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic [0:0] {StRun, StMduWait} state_e;

    localparam logic       MduMulti  = (MDU_LAT > 1);
    localparam logic [3:0] MduLoad   = MduMulti ? 4'(MDU_LAT - 2) : 4'd0;
    localparam logic [7:0] BusyLimit = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [3:0]  mdu_cnt_q, mdu_cnt_d;
    logic [7:0]  busy_cnt_q, busy_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    logic load_use;
    logic mdu_stall;

    // x0 never carries a real dependence, so a load to x0 cannot stall.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    assign mdu_stall = (state_q == StMduWait) || (ex_mdu_start && MduMulti);

    always_comb begin
        pc_write_en  = 1'b1;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        idex_bubble  = 1'b0;
        exmem_hold   = 1'b0;
        exmem_bubble = 1'b0;
        memwb_bubble = 1'b0;
        if (rst) begin
            pc_write_en  = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            memwb_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write_en  = 1'b0;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (mdu_stall) begin
            pc_write_en  = 1'b0;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
        end else if (branch_taken && (state_q == StRun)) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
        end else if (load_use) begin
            pc_write_en  = 1'b0;
            ifid_hold    = 1'b1;
            idex_bubble  = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        if (!mem_busy) begin
            unique case (state_q)
                StRun: begin
                    if (ex_mdu_start && MduMulti) begin
                        state_d   = StMduWait;
                        mdu_cnt_d = MduLoad;
                    end
                end
                StMduWait: begin
                    if (mdu_cnt_q == 4'd0) begin
                        state_d = StRun;
                    end else begin
                        mdu_cnt_d = mdu_cnt_q - 4'd1;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        busy_cnt_d = 8'd0;
        if (mem_busy) begin
            busy_cnt_d = (busy_cnt_q == 8'hFF) ? busy_cnt_q : busy_cnt_q + 8'd1;
        end
        mem_timeout_d  = mem_timeout_q | (mem_busy && (busy_cnt_q == BusyLimit));
        stall_cycles_d = stall_cycles_q;
        if (!pc_write_en && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StRun;
            mdu_cnt_q      <= 4'd0;
            busy_cnt_q     <= 8'd0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            mdu_cnt_q      <= mdu_cnt_d;
            busy_cnt_q     <= busy_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;

endmodule
